// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle core with req/ack instruction and data ports.
// Each instruction walks FETCH -> EXEC -> (MEM) -> (WB) -> FETCH.
module cpu_multicycle #(
    parameter int DATA_W = 32,
    parameter int PC_W = 26,
    parameter int ADDR_W = 12,
    parameter int NREGS = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [PC_W-1:0]   pc_out,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);

    localparam int RI_W = $clog2(NREGS);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]        state;
    logic [PC_W-1:0]   pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] regs [NREGS];

    logic [5:0]        func;
    logic [RI_W-1:0]   rs1, rs2, rd;
    logic signed [15:0] imm;
    logic              rtype;
    logic [DATA_W-1:0] a, b, imm_d, ea, alu;
    logic [PC_W-1:0]   pc_inc, pc_br;
    logic              unused_ok;

    assign func  = ir[31:26];
    assign rs1   = ir[21 +: RI_W];
    assign rs2   = ir[16 +: RI_W];
    assign imm   = ir[15:0];
    assign rtype = (func >= 6'h01) && (func <= 6'h05);
    // I-type results land in the src2 slot since dest overlaps imm16
    assign rd    = rtype ? ir[11 +: RI_W] : rs2;

    assign a      = regs[rs1];
    assign b      = regs[rs2];
    assign imm_d  = DATA_W'(imm);
    assign ea     = a + imm_d;
    assign pc_inc = pc + PC_W'(1);
    assign pc_br  = pc_inc + PC_W'(imm);

    assign imem_addr = pc;
    assign pc_out    = pc;
    assign unused_ok = ^ea;

    always_comb begin
        alu = ea;
        case (func)
            6'h01:   alu = a + b;
            6'h02:   alu = a - b;
            6'h03:   alu = a & b;
            6'h04:   alu = a | b;
            6'h05:   alu = a ^ b;
            default: alu = ea;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            res        <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            retire     <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_req && imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_EXEC;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (func)
                        6'h00: begin
                            pc       <= pc_inc;
                            retire   <= 1'b1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06: begin
                            res   <= alu;
                            state <= S_WB;
                        end
                        6'h07, 6'h08: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= func[3];
                            dmem_addr  <= ea[ADDR_W-1:0];
                            dmem_wdata <= b;
                            state      <= S_MEM;
                        end
                        6'h09: begin
                            pc       <= (a == b) ? pc_br : pc_inc;
                            retire   <= 1'b1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        6'h0A: begin
                            pc       <= PC_W'(ir[25:0]);
                            retire   <= 1'b1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        6'h3F: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                            state   <= S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (dmem_we) begin
                            pc       <= pc_inc;
                            retire   <= 1'b1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            res   <= dmem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (rd != '0) regs[rd] <= res;
                    pc       <= pc_inc;
                    retire   <= 1'b1;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: programmable req/ack memories, store/fetch
// scoreboards, and a second 16-bit/8-register instance.
module tb_cpu_multicycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic        retire, halted, illegal;
    logic [25:0] imem_addr, pc_out;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata;
    logic [11:0] dmem_addr;

    logic        b_imem_req, b_dmem_req, b_dmem_we;
    logic        b_retire, b_halted, b_illegal;
    logic [25:0] b_imem_addr, b_pc_out;
    logic [31:0] b_imem_rdata;
    logic [15:0] b_dmem_wdata;
    logic [11:0] b_dmem_addr;

    logic [31:0] imem [0:63];
    logic [31:0] imem_b [0:63];
    logic [31:0] dmem_init [0:63];

    int i_wait = 0, d_wait = 0, icnt, dcnt;
    int n_tot = 0, n_bad = 0;
    int ret_a, ret_b, lat_cnt, lat, ld_cyc;
    logic [11:0] ld_addr;
    logic addr_moved;
    logic chk_f = 1'b0;

    logic [63:0] stq [$];
    logic [63:0] exf [$];

    cpu_multicycle u_dut (
        .clk(clk), .reset(rst_a),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .pc_out(pc_out), .retire(retire),
        .halted(halted), .illegal(illegal)
    );

    cpu_multicycle #(.DATA_W(16), .NREGS(8)) u_dut16 (
        .clk(clk), .reset(rst_b),
        .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_rdata(b_imem_rdata), .imem_ack(b_imem_req),
        .dmem_req(b_dmem_req), .dmem_we(b_dmem_we),
        .dmem_addr(b_dmem_addr), .dmem_wdata(b_dmem_wdata),
        .dmem_rdata(16'h0000), .dmem_ack(b_dmem_req),
        .pc_out(b_pc_out), .retire(b_retire),
        .halted(b_halted), .illegal(b_illegal)
    );

    assign imem_rdata   = imem[imem_addr[5:0]];
    assign b_imem_rdata = imem_b[b_imem_addr[5:0]];
    assign dmem_rdata   = dmem_init[dmem_addr[5:0]];
    assign imem_ack     = imem_req && (icnt >= i_wait);
    assign dmem_ack     = dmem_req && (dcnt >= d_wait);

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input logic [63:0] got);
        if (stq.size() == 0) chk("st_extra", 64'(stq.size()), 64'd1);
        else chk("store", got, stq.pop_front());
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op,
        input logic [4:0] s1, input logic [4:0] s2, input logic [15:0] im);
        return {op, s1, s2, im};
    endfunction

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        end
    end

    always @(posedge clk) begin
        if (!rst_a) begin
            ret_a      <= 0;
            lat_cnt    <= 0;
            lat        <= -1;
            ld_cyc     <= 0;
            addr_moved <= 1'b0;
        end else begin
            if (retire) ret_a <= ret_a + 1;
            if (lat < 0) begin
                if (retire) lat <= lat_cnt;
                else if (lat_cnt > 0 || imem_req) lat_cnt <= lat_cnt + 1;
            end
            if (dmem_req && !dmem_we) begin
                ld_cyc <= ld_cyc + 1;
                if (ld_cyc == 0) ld_addr <= dmem_addr;
                else if (dmem_addr != ld_addr) addr_moved <= 1'b1;
            end
            if (dmem_req && dmem_ack && dmem_we)
                sb_pop({32'(dmem_addr), dmem_wdata});
            if (chk_f && imem_req && imem_ack) begin
                if (exf.size() == 0) chk("fetch_extra", 64'(exf.size()), 64'd1);
                else chk("fetch", 64'(imem_addr), exf.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_b) ret_b <= 0;
        else begin
            if (b_retire) ret_b <= ret_b + 1;
            if (b_dmem_req && b_dmem_we)
                sb_pop({32'(b_dmem_addr), 32'(b_dmem_wdata)});
        end
    end

    task automatic clr_prog();
        for (int i = 0; i < 64; i++) imem[i] = 32'hFC00_0000;
    endtask

    task automatic start();
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
    endtask

    task automatic wait_halt(input int lim);
        for (int i = 0; i < lim && !halted; i++) @(negedge clk);
        chk("halt_timeout", 64'(halted), 64'd1);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 64; i++) begin
            dmem_init[i] = 32'h0;
            imem_b[i] = 32'hFC00_0000;
        end
        dmem_init[8] = 32'hDEAD_BEEF;
        clr_prog();
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_ireq", 64'(imem_req), 64'd0);
        chk("rst_dreq", 64'(dmem_req), 64'd0);
        chk("rst_we", 64'(dmem_we), 64'd0);
        chk("rst_ret", 64'(retire), 64'd0);
        chk("rst_halt", 64'(halted), 64'd0);
        chk("rst_ill", 64'(illegal), 64'd0);
        chk("rst_pc", 64'(pc_out), 64'd0);
        chk("rst_daddr", 64'(dmem_addr), 64'd0);
        chk("rst_wdata", 64'(dmem_wdata), 64'd0);

        // 1: ALU program and store
        imem[0] = enc(6'h06, 5'd0, 5'd1, 16'd5);
        imem[1] = enc(6'h06, 5'd0, 5'd2, 16'hFFFD);
        imem[2] = enc(6'h01, 5'd1, 5'd2, {5'd3, 11'd0});
        imem[3] = enc(6'h08, 5'd0, 5'd3, 16'd4);
        stq.push_back({32'd4, 32'd2});
        rst_a = 1'b1;
        chk("req_pre", 64'(imem_req), 64'd0);
        @(negedge clk);
        chk("req_first", 64'(imem_req), 64'd1);
        chk("addr_first", 64'(imem_addr), 64'd0);
        wait_halt(200);
        chk("t1_ill", 64'(illegal), 64'd0);
        chk("t1_pc", 64'(pc_out), 64'd4);
        chk("t1_ret", 64'(ret_a), 64'd4);
        chk("t1_lat", 64'(lat), 64'd3);
        chk("t1_stq", 64'(stq.size()), 64'd0);
        chk("t1_ireq", 64'(imem_req), 64'd0);

        // 2: load with three data wait cycles
        clr_prog();
        d_wait = 3;
        imem[0] = enc(6'h07, 5'd0, 5'd4, 16'd8);
        imem[1] = enc(6'h08, 5'd0, 5'd4, 16'd9);
        stq.push_back({32'd9, 32'hDEAD_BEEF});
        start();
        wait_halt(200);
        chk("t2_ldcyc", 64'(ld_cyc), 64'd4);
        chk("t2_stable", 64'(addr_moved), 64'd0);
        chk("t2_lat", 64'(lat), 64'd7);
        chk("t2_ret", 64'(ret_a), 64'd2);
        chk("t2_stq", 64'(stq.size()), 64'd0);
        d_wait = 0;

        // 3: branches and jumps, checked through fetch order
        clr_prog();
        imem[0]  = enc(6'h06, 5'd0, 5'd1, 16'd1);
        imem[1]  = enc(6'h06, 5'd0, 5'd2, 16'd2);
        imem[2]  = {6'h0A, 26'd10};
        imem[10] = enc(6'h09, 5'd1, 5'd1, 16'd2);
        imem[13] = enc(6'h09, 5'd1, 5'd2, 16'd5);
        imem[14] = {6'h0A, 26'h20};
        foreach (exf[i]) exf.delete(i);
        exf.push_back(64'd0);
        exf.push_back(64'd1);
        exf.push_back(64'd2);
        exf.push_back(64'd10);
        exf.push_back(64'd13);
        exf.push_back(64'd14);
        exf.push_back(64'd32);
        chk_f = 1'b1;
        start();
        wait_halt(200);
        chk_f = 1'b0;
        chk("t3_fetchq", 64'(exf.size()), 64'd0);
        chk("t3_pc", 64'(pc_out), 64'd32);
        chk("t3_ret", 64'(ret_a), 64'd6);

        // 4: r0 stays zero
        clr_prog();
        imem[0] = enc(6'h06, 5'd0, 5'd0, 16'd7);
        imem[1] = enc(6'h08, 5'd0, 5'd0, 16'd0);
        stq.push_back({32'd0, 32'd0});
        start();
        wait_halt(200);
        chk("t4_ret", 64'(ret_a), 64'd2);
        chk("t4_stq", 64'(stq.size()), 64'd0);

        // 5: undefined opcode
        clr_prog();
        for (int i = 0; i < 6; i++) imem[i] = 32'h0;
        imem[6] = 32'h5400_0000;
        start();
        wait_halt(200);
        chk("t5_ill", 64'(illegal), 64'd1);
        chk("t5_pc", 64'(pc_out), 64'd6);
        chk("t5_ret", 64'(ret_a), 64'd6);
        k = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req) k++;
        end
        chk("t5_noreq", 64'(k), 64'd0);

        // 6: reset mid-fetch
        clr_prog();
        for (int i = 0; i < 10; i++) imem[i] = 32'h0;
        start();
        for (int i = 0; i < 100 && pc_out != 26'd9; i++) @(negedge clk);
        chk("t6_pc9", 64'(pc_out), 64'd9);
        i_wait = 100;
        repeat (2) @(negedge clk);
        chk("t6_wait", 64'(imem_req), 64'd1);
        rst_a = 1'b0;
        #1;
        chk("t6_rreq", 64'(imem_req), 64'd0);
        chk("t6_rpc", 64'(pc_out), 64'd0);
        i_wait = 0;
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk("t6_req", 64'(imem_req), 64'd1);
        chk("t6_addr", 64'(imem_addr), 64'd0);
        wait_halt(200);
        chk("t6_pc", 64'(pc_out), 64'd10);

        // 7: 16-bit, 8-register instance
        imem_b[0] = enc(6'h06, 5'd0, 5'd9, 16'h7FFF);
        imem_b[1] = enc(6'h06, 5'd1, 5'd1, 16'd1);
        imem_b[2] = enc(6'h08, 5'd0, 5'd1, 16'd3);
        imem_b[3] = enc(6'h01, 5'd1, 5'd1, {5'd2, 11'd0});
        imem_b[4] = enc(6'h08, 5'd0, 5'd2, 16'd5);
        stq.push_back({32'd3, 32'h8000});
        stq.push_back({32'd5, 32'h0});
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 200 && !b_halted; i++) @(negedge clk);
        chk("t7_halt", 64'(b_halted), 64'd1);
        chk("t7_ill", 64'(b_illegal), 64'd0);
        chk("t7_pc", 64'(b_pc_out), 64'd5);
        chk("t7_ret", 64'(ret_b), 64'd5);
        chk("t7_stq", 64'(stq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
- Parametrised multi-cycle successor to the single-cycle CPU top.
- Sequences each instruction through FETCH/EXEC/MEM/WB, so instruction and data memories may take any number of cycles; both memory ports use a req/ack handshake.
- Contains its own register file and ALU datapath. Instruction format is unchanged: func[31:26], src1[25:21], src2[20:16], dest[15:11], imm16[15:0].
- Sits between program memory and data RAM.

Parameters:
- DATA_W, 32, register/ALU/data-bus width (16..32).
- PC_W, 26, program counter width.
- ADDR_W, 12, data-memory address width.
- NREGS, 32, register count; power of 2, ≤32; register index = field mod NREGS.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= PC).
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1.
- dmem_ack  in  1  data access complete.
- pc_out  out  PC_W  current PC.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped.
- illegal  out  1  stopped on an undefined opcode.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=FETCH, PC=RESET_PC, all registers=0.
  - imem_req, dmem_req, dmem_we, retire, halted, illegal = 0.
  - dmem_addr=0, dmem_wdata=0.
- Reset mid-transaction abandons the access. The first request after release goes out on the first clk edge after reset deasserts.
- Opcodes:
  - 00 NOP.
  - 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR: dest = src1 op src2.
  - 06 ADDI: dest = src1 + sext(imm16).
  - 07 LD: dest = mem[src1 + sext(imm)].
  - 08 ST: mem[src1 + sext(imm)] = src2.
  - 09 BEQ: if src1 == src2 then PC = PC + 1 + sext(imm), else PC + 1.
  - 0A JMP: PC = instr[25:0] truncated to PC_W.
  - 3F HALT.
  - Any other opcode: halt with illegal=1.
- Arithmetic wraps modulo 2^DATA_W. PC arithmetic wraps modulo 2^PC_W. The effective address uses the low ADDR_W bits of the sum.
- Register 0 reads 0; writes to it are discarded.
- FETCH:
  - imem_req=1 with imem_addr=PC, held stable until imem_ack is sampled high. Ack in the same cycle as req is legal.
  - On ack: latch the instruction and go to EXEC. imem_req drops in the next cycle.
- EXEC:
  - Read registers and compute the ALU result / effective address / branch target.
  - LD/ST → MEM.
  - ALU ops and ADDI → WB.
  - NOP/BEQ/JMP: update PC, pulse retire, → FETCH.
  - HALT/illegal → HALTED.
- MEM:
  - dmem_req=1; dmem_addr, dmem_we and dmem_wdata held stable until dmem_ack.
  - Store: on ack, PC+1, retire, → FETCH.
  - Load: on ack, latch dmem_rdata, → WB.
- WB: write dest, PC+1, retire=1, → FETCH.
- Latency with zero-wait ack:
  - ALU/LD: 3 and 4 cycles per instruction.
  - ST/branch/NOP: 3 and 2 cycles.
  - Each wait cycle of ack adds 1.
- HALTED: terminal until reset.
  - halted=1; all requests 0.
  - pc_out holds the address of the HALT/illegal instruction.
  - No retire for the halting instruction.
- Ack while the corresponding req=0 is ignored.
- pc_out always equals the PC register.
- BEQ with offset −1 loops on itself; this is legal.

Test Plan:
1. Program ADDI r1,r0,5; ADDI r2,r0,−3; ADD r3,r1,r2; ST r3,[r0+4]; HALT, zero-wait memories → store to dmem_addr=4 with wdata=2; 4 retire pulses; halted=1; pc_out=4.
2. LD r4,[r0+8] with dmem_ack delayed 3 cycles and mem[8]=0xDEADBEEF → dmem_req and address stable for 4 cycles; r4=0xDEADBEEF, visible via a later ST; instruction takes 7 cycles.
3. BEQ r1,r1,+2 at PC=10 → next imem_addr=13. BEQ r1,r2 with r1≠r2 → next imem_addr=11. JMP 0x20 → next imem_addr=0x20.
4. ADDI r0,r0,7; ST r0,[r0+0] → wdata=0.
5. Opcode 0x15 at PC=6 → halted=1, illegal=1, pc_out=6, no further imem_req.
6. Assert reset during the third wait cycle of a fetch at PC=9 → immediately imem_req=0 and pc_out=0. After release, fetch restarts at address 0.
7. With DATA_W=16, NREGS=8: ADDI r9,r0,0x7FFF then ADDI r1,r1,1 → write goes to r1; r1 wraps to 0x8000.
